// File: rtl/wb_fwd_stage_pkg.sv
// Shared types and helpers for the MEM/WB back end.
// Forward-select encoding and load-type codes.
package wb_fwd_stage_pkg;

  localparam logic [2:0] FW_RF  = 3'd0;
  localparam logic [2:0] FW_ALU = 3'd1;
  localparam logic [2:0] FW_MEM = 3'd2;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_W    = 3'd1,
    LD_B    = 3'd2,
    LD_BU   = 3'd3,
    LD_H    = 3'd4,
    LD_HU   = 3'd5
  } ld_t;

  function automatic ld_t norm_ld(
    input logic [2:0] code
  );
    if (code > 3'd5) return LD_NONE;
    return ld_t'(code);
  endfunction

  // Loads in MEM cannot forward yet; they fall through to WB/RF.
  function automatic logic [2:0] fw_sel(
    input logic [4:0] n,
    input logic       mem_we,
    input logic [4:0] mem_rd,
    input logic       mem_is_ld,
    input logic       wb_we,
    input logic [4:0] wb_addr
  );
    if (n == 5'd0)
      return FW_RF;
    if (mem_we && mem_rd == n && !mem_is_ld)
      return FW_ALU;
    if (wb_we && wb_addr == n)
      return FW_MEM;
    return FW_RF;
  endfunction

endpackage

// File: rtl/wb_fwd_stage_ld_fmt.sv
// Load data aligner: big-endian lane select plus
// sign/zero extension.
module ld_fmt
  import wb_fwd_stage_pkg::*;
(
  input  logic [2:0]  ld_ctl,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = din[31:24];
    unique case (addr_lo)
      2'd0: lane_b = din[31:24];
      2'd1: lane_b = din[23:16];
      2'd2: lane_b = din[15:8];
      2'd3: lane_b = din[7:0];
      default: lane_b = din[31:24];
    endcase
  end

  assign lane_h = addr_lo[1] ? din[15:0]
                             : din[31:16];

  always_comb begin
    dout = din;
    case (norm_ld(ld_ctl))
      LD_B:  dout = {{24{lane_b[7]}}, lane_b};
      LD_BU: dout = {24'd0, lane_b};
      LD_H:  dout = {{16{lane_h[15]}}, lane_h};
      LD_HU: dout = {16'd0, lane_h};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/wb_fwd_stage.sv
// MEM/WB registers, register-file write port,
// forwarding selects and load-use stall.
module wb_fwd_stage
  import wb_fwd_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          pause,
  input  logic [DW-1:0] ex_alu_i,
  input  logic [AW-1:0] ex_rd_i,
  input  logic          ex_we_i,
  input  logic [2:0]    ex_ld_ctl_i,
  input  logic [DW-1:0] dmem_i,
  input  logic [AW-1:0] rs_n_i,
  input  logic [AW-1:0] rt_n_i,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_din_o,
  output logic [DW-1:0] fw_alu_o,
  output logic [DW-1:0] fw_mem_o,
  output logic [2:0]    fw_cmp_rs_o,
  output logic [2:0]    fw_cmp_rt_o,
  output logic          ld_stall_o
);

  logic [DW-1:0] mem_alu;
  logic [AW-1:0] mem_rd;
  logic          mem_we;
  ld_t           mem_ld;

  logic [DW-1:0] wb_din;
  logic [AW-1:0] wb_addr;
  logic          wb_we;

  logic [DW-1:0] ld_data;
  logic [DW-1:0] wb_din_n;
  logic          mem_is_ld;

  ld_fmt u_fmt (
    .ld_ctl  (mem_ld),
    .addr_lo (mem_alu[1:0]),
    .din     (dmem_i),
    .dout    (ld_data)
  );

  assign mem_is_ld = (mem_ld != LD_NONE);
  assign wb_din_n  = mem_is_ld ? ld_data : mem_alu;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      mem_alu <= '0;
      mem_rd  <= '0;
      mem_we  <= 1'b0;
      mem_ld  <= LD_NONE;
      wb_din  <= '0;
      wb_addr <= '0;
      wb_we   <= 1'b0;
    end else if (!pause) begin
      mem_alu <= ex_alu_i;
      mem_rd  <= ex_rd_i;
      mem_we  <= ex_we_i && (ex_rd_i != '0);
      mem_ld  <= norm_ld(ex_ld_ctl_i);
      wb_din  <= wb_din_n;
      wb_addr <= mem_rd;
      wb_we   <= mem_we;
    end
  end

  assign wb_we_o   = wb_we;
  assign wb_addr_o = wb_addr;
  assign wb_din_o  = wb_din;
  assign fw_alu_o  = mem_alu;
  assign fw_mem_o  = wb_din;

  assign fw_cmp_rs_o = fw_sel(rs_n_i, mem_we, mem_rd,
                              mem_is_ld, wb_we, wb_addr);
  assign fw_cmp_rt_o = fw_sel(rt_n_i, mem_we, mem_rd,
                              mem_is_ld, wb_we, wb_addr);

  assign ld_stall_o = mem_we && mem_is_ld &&
                      (mem_rd != '0) &&
                      (mem_rd == rs_n_i ||
                       mem_rd == rt_n_i);

endmodule

// File: tb/tb_wb_fwd_stage.sv
// Directed bench for wb_fwd_stage with a write-port
// scoreboard fed at EX and drained at WB.
module tb_wb_fwd_stage;

  localparam logic [2:0] S_RF  = 3'd0;
  localparam logic [2:0] S_ALU = 3'd1;
  localparam logic [2:0] S_MEM = 3'd2;

  logic        clk;
  logic        rst_i;
  logic        pause;
  logic [31:0] ex_alu_i;
  logic [4:0]  ex_rd_i;
  logic        ex_we_i;
  logic [2:0]  ex_ld_ctl_i;
  logic [31:0] dmem_i;
  logic [4:0]  rs_n_i;
  logic [4:0]  rt_n_i;
  logic        wb_we_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_din_o;
  logic [31:0] fw_alu_o;
  logic [31:0] fw_mem_o;
  logic [2:0]  fw_cmp_rs_o;
  logic [2:0]  fw_cmp_rt_o;
  logic        ld_stall_o;

  wb_fwd_stage dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .pause       (pause),
    .ex_alu_i    (ex_alu_i),
    .ex_rd_i     (ex_rd_i),
    .ex_we_i     (ex_we_i),
    .ex_ld_ctl_i (ex_ld_ctl_i),
    .dmem_i      (dmem_i),
    .rs_n_i      (rs_n_i),
    .rt_n_i      (rt_n_i),
    .wb_we_o     (wb_we_o),
    .wb_addr_o   (wb_addr_o),
    .wb_din_o    (wb_din_o),
    .fw_alu_o    (fw_alu_o),
    .fw_mem_o    (fw_mem_o),
    .fw_cmp_rs_o (fw_cmp_rs_o),
    .fw_cmp_rt_o (fw_cmp_rt_o),
    .ld_stall_o  (ld_stall_o)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fmt_m(
    input logic [2:0]  ld,
    input logic [1:0]  lo,
    input logic [31:0] d
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> (8 * (3 - int'(lo))));
    h = lo[1] ? d[15:0] : d[31:16];
    case (ld)
      3'd2: return {{24{b[7]}}, b};
      3'd3: return {24'd0, b};
      3'd4: return {{16{h[15]}}, h};
      3'd5: return {16'd0, h};
      default: return d;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a,
                       input logic [4:0]  rd,
                       input logic        we,
                       input logic [2:0]  ld);
    wr_t e;
    ex_alu_i    = a;
    ex_rd_i     = rd;
    ex_we_i     = we;
    ex_ld_ctl_i = ld;
    if (we && rd != 5'd0) begin
      e.a = rd;
      e.d = (ld >= 3'd1 && ld <= 3'd5)
          ? fmt_m(ld, a[1:0], dmem_i) : a;
      q.push_back(e);
    end
  endtask

  task automatic bubble();
    drive(32'd0, 5'd0, 1'b0, 3'd0);
  endtask

  task automatic ld_check(input logic [2:0]  ld,
                          input logic [1:0]  lo,
                          input logic [31:0] exp,
                          input string       tag);
    drive({30'h40, lo}, 5'd20, 1'b1, ld);
    tick();
    bubble();
    tick();
    chk(tag, wb_din_o, exp);
  endtask

  // Scoreboard drain: a write is new only after an
  // un-paused, un-reset edge.
  initial begin : mon
    logic p, r;
    wr_t  e;
    forever begin
      @(posedge clk);
      p = pause;
      r = rst_i;
      #1;
      if (!p && !r && wb_we_o === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL sb_extra: observed r%0d=%h expected none",
                 wb_addr_o, wb_din_o);
        end else begin
          e = q.pop_front();
          chk("sb_addr", 32'(wb_addr_o), 32'(e.a));
          chk("sb_data", wb_din_o, e.d);
        end
      end
    end
  end

  initial begin
    logic [31:0] snap_din;
    rst_i  = 1'b1;
    pause  = 1'b0;
    dmem_i = 32'd0;
    rs_n_i = 5'd0;
    rt_n_i = 5'd0;
    bubble();
    tick();
    tick();
    rs_n_i = 5'd5;
    rt_n_i = 5'd7;
    #1;
    chk("rst_we",    32'(wb_we_o), 32'd0);
    chk("rst_addr",  32'(wb_addr_o), 32'd0);
    chk("rst_din",   wb_din_o, 32'd0);
    chk("rst_fwalu", fw_alu_o, 32'd0);
    chk("rst_fwmem", fw_mem_o, 32'd0);
    chk("rst_rs",    32'(fw_cmp_rs_o), 32'(S_RF));
    chk("rst_rt",    32'(fw_cmp_rt_o), 32'(S_RF));
    chk("rst_stall", 32'(ld_stall_o), 32'd0);
    rst_i  = 1'b0;
    rs_n_i = 5'd0;
    rt_n_i = 5'd0;

    // ALU chain
    drive(32'h1234_5678, 5'd5, 1'b1, 3'd0);
    tick();
    bubble();
    rs_n_i = 5'd5;
    #1;
    chk("t1_rs_alu", 32'(fw_cmp_rs_o), 32'(S_ALU));
    chk("t1_fwalu",  fw_alu_o, 32'h1234_5678);
    tick();
    chk("t1_rs_mem", 32'(fw_cmp_rs_o), 32'(S_MEM));
    chk("t1_fwmem",  fw_mem_o, 32'h1234_5678);
    chk("t1_we",     32'(wb_we_o), 32'd1);
    chk("t1_addr",   32'(wb_addr_o), 32'd5);
    rs_n_i = 5'd0;
    tick();

    // Load-use
    dmem_i = 32'h11F2_3344;
    drive(32'h0000_0101, 5'd7, 1'b1, 3'd2);
    tick();
    bubble();
    rt_n_i = 5'd7;
    #1;
    chk("t2_stall1", 32'(ld_stall_o), 32'd1);
    chk("t2_rt_rf",  32'(fw_cmp_rt_o), 32'(S_RF));
    tick();
    chk("t2_stall0", 32'(ld_stall_o), 32'd0);
    chk("t2_rt_mem", 32'(fw_cmp_rt_o), 32'(S_MEM));
    chk("t2_din",    wb_din_o, 32'hFFFF_FFF2);
    rt_n_i = 5'd0;

    // Formatter
    dmem_i = 32'h8001_7F80;
    ld_check(3'd5, 2'd2, 32'h0000_7F80, "t3_lhu2");
    ld_check(3'd4, 2'd0, 32'hFFFF_8001, "t3_lh0");
    ld_check(3'd3, 2'd3, 32'h0000_0080, "t3_lbu3");
    ld_check(3'd2, 2'd2, 32'h0000_007F, "t3_lb2");
    ld_check(3'd4, 2'd3, 32'h0000_7F80, "t3_lh3");
    for (int ld = 1; ld <= 5; ld++) begin
      for (int lo = 0; lo < 4; lo++) begin
        drive(32'h0000_0200 + 32'(lo), {3'(ld), 2'(lo)},
              1'b1, 3'(ld));
        tick();
      end
    end
    bubble();
    tick();
    tick();

    // Priority and r0
    drive(32'hBBBB_0003, 5'd3, 1'b1, 3'd0);
    tick();
    drive(32'hAAAA_0003, 5'd3, 1'b1, 3'd0);
    tick();
    rs_n_i = 5'd3;
    rt_n_i = 5'd3;
    #1;
    chk("t4_rs_alu", 32'(fw_cmp_rs_o), 32'(S_ALU));
    chk("t4_rt_alu", 32'(fw_cmp_rt_o), 32'(S_ALU));
    chk("t4_fwalu",  fw_alu_o, 32'hAAAA_0003);
    chk("t4_fwmem",  fw_mem_o, 32'hBBBB_0003);
    drive(32'hDEAD_BEEF, 5'd0, 1'b1, 3'd0);
    rs_n_i = 5'd0;
    rt_n_i = 5'd0;
    tick();
    chk("t4_r0_rs", 32'(fw_cmp_rs_o), 32'(S_RF));
    bubble();
    tick();
    chk("t4_r0_we", 32'(wb_we_o), 32'd0);
    chk("t4_r0_rt", 32'(fw_cmp_rt_o), 32'(S_RF));

    // Pause
    drive(32'hC0C0_0009, 5'd9, 1'b1, 3'd0);
    tick();
    drive(32'hD0D0_000A, 5'd10, 1'b1, 3'd0);
    tick();
    drive(32'hE0E0_000B, 5'd11, 1'b1, 3'd0);
    pause = 1'b1;
    snap_din = wb_din_o;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_din",   wb_din_o, snap_din);
      chk("t5_addr",  32'(wb_addr_o), 32'd9);
      chk("t5_we",    32'(wb_we_o), 32'd1);
      chk("t5_fwalu", fw_alu_o, 32'hD0D0_000A);
    end
    rs_n_i = 5'd10;
    rt_n_i = 5'd9;
    #1;
    chk("t5_rs_alu", 32'(fw_cmp_rs_o), 32'(S_ALU));
    chk("t5_rt_mem", 32'(fw_cmp_rt_o), 32'(S_MEM));
    pause = 1'b0;
    tick();
    chk("t5_rel_addr",  32'(wb_addr_o), 32'd10);
    chk("t5_rel_fwalu", fw_alu_o, 32'hE0E0_000B);
    bubble();
    rs_n_i = 5'd0;
    rt_n_i = 5'd0;
    tick();
    chk("t5_rel2_addr", 32'(wb_addr_o), 32'd11);
    tick();

    // Reset mid-flight
    dmem_i = 32'h5555_AAAA;
    drive(32'h0000_0300, 5'd12, 1'b1, 3'd1);
    tick();
    rt_n_i = 5'd12;
    #1;
    chk("t6_stall_pre", 32'(ld_stall_o), 32'd1);
    pause = 1'b1;
    rst_i = 1'b1;
    bubble();
    q.delete();
    tick();
    chk("t6_we",    32'(wb_we_o), 32'd0);
    chk("t6_din",   wb_din_o, 32'd0);
    chk("t6_stall", 32'(ld_stall_o), 32'd0);
    chk("t6_rt",    32'(fw_cmp_rt_o), 32'(S_RF));
    chk("t6_rs",    32'(fw_cmp_rs_o), 32'(S_RF));
    rst_i = 1'b0;
    pause = 1'b0;
    tick();
    tick();
    tick();
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
